simon_seq_player: RTL and testbench

- Playback stage that shows the stored Simon colour sequence on LD0–LD3 before the player's input phase.
- Sits directly downstream of the sequence store.
- Reads one 2-bit colour per step through a synchronous read port and lights the matching LED for a fixed on-time, then a fixed gap.
- Pulses done to the game FSM when the sequence has been shown.

---
 rtl/simon_pkg.sv | 33 +++
 rtl/simon_dwell_timer.sv | 30 +++
 rtl/simon_seq_player.sv | 141 ++++++++++++++
 tb/tb_simon_seq_player.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared Simon definitions: colour codes, colour-to-LED mapping and the
// playback state encoding. The game FSM and the debug display use these too.
package simon_pkg;

  localparam logic [1:0] COL_U = 2'd0;
  localparam logic [1:0] COL_L = 2'd1;
  localparam logic [1:0] COL_R = 2'd2;
  localparam logic [1:0] COL_D = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_ON,
    ST_GAP,
    ST_DONE
  } player_state_e;

  // One-hot LED pattern for a colour: LD0 = up, LD1 = left, LD2 = right, LD3 = down.
  function automatic logic [3:0] colour_led(input logic [1:0] colour);
    logic [3:0] led;
    led = 4'b0000;
    case (colour)
      COL_U:   led = 4'b0001;
      COL_L:   led = 4'b0010;
      COL_R:   led = 4'b0100;
      COL_D:   led = 4'b1000;
      default: led = 4'b0000;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/simon_dwell_timer.sv
// Loadable down-counter used for both the LED on-time and the dark gap.
// expired is high whenever the count has reached zero; it never wraps.
module simon_dwell_timer #(
  parameter int W = 6
) (
  input  logic         btn_clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] count;

  // Count register: load has priority, otherwise decrement and hold at zero.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge btn_clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/simon_seq_player.sv
// Plays the stored Simon colour sequence on LD0-LD3: for each step it reads
// the colour from the store, lights its LED for ON_TICKS cycles, then leaves
// the LEDs dark for OFF_TICKS cycles. Pulses done once the sequence is shown.
module simon_seq_player
  import simon_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int ON_TICKS  = 48,
  parameter int OFF_TICKS = 24
) (
  input  logic              btn_clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_data,
  output logic [3:0]        led,
  output logic              busy,
  output logic              done
);

  localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  player_state_e     state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [ADDR_W:0]   len, len_n;
  logic [1:0]        colour, colour_n;
  logic [3:0]        led_n;
  logic              tmr_load, tmr_en, tmr_expired;
  logic [CNT_W-1:0]  tmr_value;
  logic              last_step;

  simon_dwell_timer #(.W(CNT_W)) u_dwell (
    .btn_clk    (btn_clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .en         (tmr_en),
    .expired    (tmr_expired)
  );

  assign last_step = ({1'b0, idx} == (len - (ADDR_W+1)'(1)));

  // Next-state and datapath decode for the playback sequence.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    len_n     = len;
    colour_n  = colour;
    led_n     = led;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    tmr_value = '0;

    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          if (length == '0) begin
            state_n = ST_DONE;
          end else begin
            len_n   = (length > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : length;
            idx_n   = '0;
            state_n = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        state_n = ST_LATCH;
      end
      ST_LATCH: begin
        colour_n  = rd_data;
        led_n     = colour_led(rd_data);
        tmr_load  = 1'b1;
        tmr_value = CNT_W'(ON_TICKS - 1);
        state_n   = ST_ON;
      end
      ST_ON: begin
        tmr_en = 1'b1;
        led_n  = colour_led(colour);
        if (tmr_expired) begin
          led_n     = 4'b0000;
          tmr_load  = 1'b1;
          tmr_value = CNT_W'(OFF_TICKS - 1);
          state_n   = ST_GAP;
        end
      end
      ST_GAP: begin
        tmr_en = 1'b1;
        led_n  = 4'b0000;
        if (tmr_expired) begin
          if (last_step) begin
            state_n = ST_DONE;
          end else begin
            idx_n   = idx + ADDR_W'(1);
            state_n = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        led_n   = 4'b0000;
        state_n = ST_IDLE;
      end
      default: begin
        led_n   = 4'b0000;
        state_n = ST_IDLE;
      end
    endcase

    // Cancel from any active state; idle ignores abort.
    if (abort && (state != ST_IDLE)) begin
      led_n   = 4'b0000;
      state_n = ST_IDLE;
    end
  end

  // State and datapath registers.
  always_ff @(posedge btn_clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      idx    <= '0;
      len    <= '0;
      colour <= '0;
      led    <= 4'b0000;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      len    <= len_n;
      colour <= colour_n;
      led    <= led_n;
    end
  end

  assign rd_addr = idx;
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_simon_seq_player.sv
// Self-checking bench for simon_seq_player with short dwell times.
// The driver issues requests and pushes the expected per-cycle display trace
// (computed from the playback rules) into a queue; the monitor pops one entry
// per cycle and compares, expecting a quiet idle display when the queue is empty.
module tb_simon_seq_player;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int ON_T   = 4;
  localparam int OFF_T  = 2;

  logic              btn_clk = 1'b0;
  logic              reset   = 1'b0;
  logic              start   = 1'b0;
  logic [ADDR_W:0]   length  = '0;
  logic              abort   = 1'b0;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        rd_data = 2'd0;
  logic [3:0]        led;
  logic              busy;
  logic              done;

  logic [1:0] mem [DEPTH];

  typedef struct {
    logic [3:0] led;
    logic       busy;
    logic       done;
    logic       chk_addr;
    logic [3:0] addr;
  } exp_t;

  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  simon_seq_player #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .ON_TICKS  (ON_T),
    .OFF_TICKS (OFF_T)
  ) dut (
    .btn_clk (btn_clk),
    .reset   (reset),
    .start   (start),
    .length  (length),
    .abort   (abort),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .led     (led),
    .busy    (busy),
    .done    (done)
  );

  always #5 btn_clk = ~btn_clk;

  // Sequence store with a one-cycle synchronous read.
  always @(posedge btn_clk) rd_data <= mem[rd_addr];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, want);
    end
  endtask

  // Monitor: one comparison per cycle, sampled on the falling edge.
  always @(negedge btn_clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("led_busy_done", 32'({led, busy, done}), 32'({e.led, e.busy, e.done}));
      if (e.chk_addr) check("rd_addr", 32'(rd_addr), 32'(e.addr));
    end else begin
      check("idle", 32'({led, busy, done}), 32'd0);
    end
  end

  function automatic logic [3:0] led_of(input logic [1:0] c);
    return 4'(1 << c);
  endfunction

  // Reference model: whole playback trace, one entry per cycle after the start edge.
  task automatic push_trace(input int n);
    int steps;
    steps = (n > DEPTH) ? DEPTH : n;
    if (steps == 0) begin
      exp_q.push_back('{led: 4'd0, busy: 1'b1, done: 1'b1, chk_addr: 1'b0, addr: 4'd0});
    end else begin
      for (int k = 0; k < steps; k++) begin
        for (int c = 0; c < 2 + ON_T + OFF_T; c++) begin
          exp_q.push_back('{led: (c >= 2 && c < 2 + ON_T) ? led_of(mem[k]) : 4'd0,
                            busy: 1'b1, done: 1'b0, chk_addr: 1'b1, addr: 4'(k)});
        end
      end
      exp_q.push_back('{led: 4'd0, busy: 1'b1, done: 1'b1, chk_addr: 1'b1, addr: 4'(steps - 1)});
    end
  endtask

  // Pulse start for one cycle; returns just after the sampling edge E0.
  task automatic issue(input int n);
    @(posedge btn_clk); #1;
    start  = 1'b1;
    length = 5'(n);
    @(posedge btn_clk); #1;
    start  = 1'b0;
    push_trace(n);
  endtask

  task automatic wait_drain(input int budget);
    int left;
    left = budget;
    while (exp_q.size() != 0 && left > 0) begin
      @(posedge btn_clk);
      left--;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge btn_clk);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = 2'($urandom_range(0, 3));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    randomize_mem();
    #1 reset = 1'b1;
    #1;
    check("reset_led",  32'(led),     32'd0);
    check("reset_busy", 32'(busy),    32'd0);
    check("reset_done", 32'(done),    32'd0);
    check("reset_addr", 32'(rd_addr), 32'd0);
    repeat (2) @(posedge btn_clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge btn_clk);

    // Directed sequence {2,0,3}, with an ignored start during ON of step 1.
    mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
    issue(3);
    repeat (11) @(posedge btn_clk);
    #1; start = 1'b1; length = 5'd5;
    @(posedge btn_clk); #1; start = 1'b0;
    wait_drain(200);

    // Zero-length request: immediate done, nothing lit.
    issue(0);
    wait_drain(20);

    // Over-long request is clamped to the store depth.
    randomize_mem();
    issue(20);
    wait_drain(400);

    // Abort during GAP of step 1, then replay from address 0.
    randomize_mem();
    issue(3);
    repeat (14) @(posedge btn_clk);
    #1 abort = 1'b1;
    @(posedge btn_clk); #1;
    abort = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge btn_clk);
    issue(4);
    wait_drain(200);

    // Abort together with start in idle: stays idle.
    @(posedge btn_clk); #1;
    start = 1'b1; abort = 1'b1; length = 5'd3;
    @(posedge btn_clk); #1;
    start = 1'b0; abort = 1'b0;
    repeat (4) @(posedge btn_clk);

    // Asynchronous reset in the middle of ON.
    issue(2);
    repeat (4) @(posedge btn_clk);
    #1 reset = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_led",  32'(led),  32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge btn_clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge btn_clk);

    // Random requests over random store contents.
    for (int r = 0; r < 4; r++) begin
      randomize_mem();
      issue($urandom_range(1, 7));
      wait_drain(200);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
